tx_block: RTL

UART-style serial transmitter. It is the upstream partner of the receiver and drives its serial_in line.
- Accepts parallel bytes through a one-entry holding buffer.
- Serialises each byte as: start bit (0), 8 data bits LSB first, stop bit (1).
- Each bit lasts BIT_PERIOD clocks. The default of 10 clocks matches the receiver's nominal data period.
- Double buffering allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 9 +
 rtl/tx_block_if.sv | 31 +++
 rtl/tx_block_flex_counter.sv | 32 +++
 rtl/tx_block.sv | 126 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and frame constants,
// also used by the matching receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DEFAULT_BIT_PERIOD = 10;
  localparam int DATA_BITS          = 8;
  localparam int IDX_BITS           = $clog2(DATA_BITS + 1);
endpackage

// File: rtl/tx_block_if.sv
// Byte-load handshake, serial line and debug taps of the UART transmitter.
interface tx_block_if #(
  parameter int CNT_BITS = 8
);
  import uart_pkg::*;

  logic [7:0]          tx_data;
  logic                load_data;
  logic                tx_ready;
  logic                tx_active;
  logic                tx_done;
  logic                overrun_error;
  logic                serial_out;
  tx_state_t           dbg_state;
  logic [CNT_BITS-1:0] dbg_bit_cnt;
  logic [IDX_BITS-1:0] dbg_bit_idx;

  // Handshake: tx_data is taken at a rising edge where load_data && tx_ready.
  // load_data with tx_ready low drops the byte and sets overrun_error.
  modport master (
    output tx_data, load_data,
    input  tx_ready, tx_active, tx_done, overrun_error, serial_out,
    input  dbg_state, dbg_bit_cnt, dbg_bit_idx
  );

  modport slave (
    input  tx_data, load_data,
    output tx_ready, tx_active, tx_done, overrun_error, serial_out,
    output dbg_state, dbg_bit_cnt, dbg_bit_idx
  );
endinterface

// File: rtl/tx_block_flex_counter.sv
// Generic up-counter: counts 1..rollover_val then wraps to 1; clear forces 0.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = NUM_CNT_BITS'(1);
      else                         count_d = count_q + NUM_CNT_BITS'(1);
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);
endmodule

// File: rtl/tx_block.sv
// UART transmitter: one-entry holding buffer feeding a start/8-data/stop
// serialiser, with back-to-back frames when the buffer refills in time.
module tx_block
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
  parameter int CNT_BITS   = 8
) (
  input  logic      clk,
  input  logic      n_rst,
  tx_block_if.slave bus
);
  tx_state_t            state_q, state_d;
  logic                 buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 active_q, done_q;
  logic                 ovr_q, ovr_d;

  logic                 accept, transfer, stop_end;
  logic                 bit_end, last_bit;
  logic                 tmr_clear, tmr_en, idx_clear, idx_en;
  logic [CNT_BITS-1:0]  bit_cnt;
  logic [IDX_BITS-1:0]  bit_idx;

  assign accept   = bus.load_data && !buf_full_q;
  assign stop_end = (state_q == STOP) && bit_end;
  assign transfer = buf_full_q && ((state_q == IDLE) || stop_end);

  // The timer counts through the transfer cycle so the start bit is exactly
  // BIT_PERIOD clocks; it is held at zero whenever the line goes idle.
  assign tmr_en    = (state_q != IDLE) || transfer;
  assign tmr_clear = (state_d == IDLE);
  assign idx_en    = bit_end && ((state_q == START) || (state_q == DATA));
  assign idx_clear = (state_q == IDLE) || (state_q == STOP);

  flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (tmr_clear),
    .count_enable (tmr_en),
    .rollover_val (CNT_BITS'(BIT_PERIOD)),
    .count_out    (bit_cnt),
    .rollover_flag(bit_end)
  );

  // Index reads 1..8 while data bit 1..8 is on the line.
  flex_counter #(.NUM_CNT_BITS(IDX_BITS)) u_bit_index (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (idx_clear),
    .count_enable (idx_en),
    .rollover_val (IDX_BITS'(DATA_BITS)),
    .count_out    (bit_idx),
    .rollover_flag(last_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (buf_full_q) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && last_bit) state_d = STOP;
      STOP:    if (bit_end) state_d = buf_full_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    ovr_d      = ovr_q;
    shift_d    = shift_q;
    serial_d   = 1'b1;
    if (accept) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
      ovr_d      = 1'b0;
    end else if (bus.load_data) begin
      ovr_d = 1'b1;
    end
    if (transfer) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
    end
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      active_q   <= (state_d != IDLE);
      done_q     <= stop_end;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.tx_ready      = !buf_full_q;
  assign bus.tx_active     = active_q;
  assign bus.tx_done       = done_q;
  assign bus.overrun_error = ovr_q;
  assign bus.serial_out    = serial_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_bit_cnt   = bit_cnt;
  assign bus.dbg_bit_idx   = bit_idx;
endmodule
